ipgu_window_sched: RTL and testbench



---
 rtl/ipgu_window_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_ipgu_window_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipgu_window_sched.sv
// ipgu_window_sched
//
// Sequences the image pyramid generation unit across all pyramid levels. For each
// level it walks WIN x WIN window origins with a stride of STEP in raster order and
// offers each origin on a valid/ready handshake. Between levels it requests a
// downscale of the current level into the next and waits for the acknowledge. A
// one-cycle done pulse marks acceptance of the last window of the last level.
//
// Optional build macro: IPGU_SCHED_PERF_EN adds the stallCnt and scaleWaitCnt
// performance counters. Without it neither port nor counter logic exists.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         begin a full pyramid pass (sampled in IDLE only)
//   busy          pass in progress
//   done          one-cycle pulse at end of pass
//   winVld/winRdy window origin handshake
//   winRow/winCol window top row / left column
//   winLevel      current pyramid level
//   winLast       current window is the last of its level
//   scaleReq      request downscale of the current level into the next
//   scaleAck      downscale complete (one-cycle pulse)
//   scaleSrcDim   dimension of the current level
//   scaleDstDim   dimension of the next level
//   stallCnt      (perf build) cycles with winVld && !winRdy, saturating
//   scaleWaitCnt  (perf build) cycles with scaleReq && !scaleAck, saturating

module ipgu_window_sched #(
  parameter int unsigned NUM_LEVELS = 6,
  parameter int unsigned COORD_W    = 9,
  parameter logic [NUM_LEVELS*COORD_W-1:0] LEVEL_DIMS =
    {9'd20, 9'd60, 9'd120, 9'd180, 9'd240, 9'd300},
  parameter int unsigned WIN        = 20,
  parameter int unsigned STEP       = 10,
  localparam int unsigned LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               winVld,
  input  logic               winRdy,
  output logic [COORD_W-1:0] winRow,
  output logic [COORD_W-1:0] winCol,
  output logic [LVL_W-1:0]   winLevel,
  output logic               winLast,
  output logic               scaleReq,
  input  logic               scaleAck,
  output logic [COORD_W-1:0] scaleSrcDim,
  output logic [COORD_W-1:0] scaleDstDim
`ifdef IPGU_SCHED_PERF_EN
  ,
  output logic [31:0]        stallCnt,
  output logic [31:0]        scaleWaitCnt
`endif
);

  typedef enum logic [1:0] {Idle, Emit, Scale, Done} state_e;

  localparam logic [LVL_W-1:0]   LastLevel = LVL_W'(NUM_LEVELS - 1);
  localparam logic [COORD_W-1:0] WinC      = COORD_W'(WIN);
  localparam logic [COORD_W-1:0] StepC     = COORD_W'(STEP);

  state_e             state;
  logic [LVL_W-1:0]   level;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;

  logic [COORD_W-1:0] dimTab [NUM_LEVELS];
  logic [LVL_W-1:0]   nextLevel;
  logic [COORD_W-1:0] curDim;
  logic [COORD_W-1:0] nxtDim;
  logic [COORD_W-1:0] lim;
  logic [COORD_W-1:0] colNext;
  logic [COORD_W-1:0] rowNext;

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : gDim
    assign dimTab[i] = LEVEL_DIMS[i*COORD_W +: COORD_W];
  end

  // nextLevel is only meaningful below LastLevel; clamp the lookup otherwise.
  assign nextLevel = level + LVL_W'(1);
  assign curDim    = dimTab[level];
  assign nxtDim    = (level == LastLevel) ? curDim : dimTab[nextLevel];
  // Largest origin on this level; legal dims keep col/row + STEP <= lim, so no wrap.
  assign lim       = curDim - WinC;
  assign colNext   = col + StepC;
  assign rowNext   = row + StepC;

  assign winRow    = row;
  assign winCol    = col;
  assign winLevel  = level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= Idle;
      level       <= '0;
      row         <= '0;
      col         <= '0;
      winVld      <= 1'b0;
      winLast     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      scaleReq    <= 1'b0;
      scaleSrcDim <= '0;
      scaleDstDim <= '0;
    end else begin
      unique case (state)
        Idle: begin
          done <= 1'b0;
          if (start) begin
            state   <= Emit;
            level   <= '0;
            row     <= '0;
            col     <= '0;
            winVld  <= 1'b1;
            busy    <= 1'b1;
            winLast <= (dimTab[0] == WinC);
          end
        end

        Emit: begin
          if (winVld && winRdy) begin
            if (col < lim) begin
              col     <= colNext;
              winLast <= (row == lim) && (colNext == lim);
            end else if (row < lim) begin
              // New row starts at col 0, which cannot be the last origin since lim > 0.
              col     <= '0;
              row     <= rowNext;
              winLast <= 1'b0;
            end else begin
              winVld  <= 1'b0;
              winLast <= 1'b0;
              if (level == LastLevel) begin
                state <= Done;
                done  <= 1'b1;
              end else begin
                state       <= Scale;
                scaleReq    <= 1'b1;
                scaleSrcDim <= curDim;
                scaleDstDim <= nxtDim;
              end
            end
          end
        end

        Scale: begin
          if (scaleAck) begin
            state       <= Emit;
            scaleReq    <= 1'b0;
            scaleSrcDim <= '0;
            scaleDstDim <= '0;
            level       <= nextLevel;
            row         <= '0;
            col         <= '0;
            winVld      <= 1'b1;
            winLast     <= (nxtDim == WinC);
          end
        end

        Done: begin
          state <= Idle;
          done  <= 1'b0;
          busy  <= 1'b0;
          level <= '0;
          row   <= '0;
          col   <= '0;
        end

        default: state <= Idle;
      endcase
    end
  end

`ifdef IPGU_SCHED_PERF_EN
  logic startAccept;
  assign startAccept = (state == Idle) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt     <= '0;
      scaleWaitCnt <= '0;
    end else if (startAccept) begin
      stallCnt     <= '0;
      scaleWaitCnt <= '0;
    end else begin
      if (winVld && !winRdy && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 32'd1;
      end
      if (scaleReq && !scaleAck && (scaleWaitCnt != '1)) begin
        scaleWaitCnt <= scaleWaitCnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Every level must hold at least one window and land exactly on the stride grid.
  function automatic bit dimsLegal();
    for (int i = 0; i < int'(NUM_LEVELS); i++) begin
      int unsigned d;
      d = 32'(LEVEL_DIMS[i*COORD_W +: COORD_W]);
      if (d < WIN) return 1'b0;
      if (((d - WIN) % STEP) != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  localparam bit DimsOk = dimsLegal();

  always @(posedge clk) begin
    if (!rst) begin
      assert (DimsOk) else $error("ipgu_window_sched: illegal LEVEL_DIMS");
    end
  end
`endif

endmodule

// File: tb/tb_ipgu_window_sched.sv
module tb_ipgu_window_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       winVld;
  logic       winRdy;
  logic [8:0] winRow;
  logic [8:0] winCol;
  logic [2:0] winLevel;
  logic       winLast;
  logic       scaleReq;
  logic       scaleAck;
  logic [8:0] scaleSrcDim;
  logic [8:0] scaleDstDim;
`ifdef IPGU_SCHED_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] scaleWaitCnt;
`endif

  ipgu_window_sched dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .winVld      (winVld),
    .winRdy      (winRdy),
    .winRow      (winRow),
    .winCol      (winCol),
    .winLevel    (winLevel),
    .winLast     (winLast),
    .scaleReq    (scaleReq),
    .scaleAck    (scaleAck),
    .scaleSrcDim (scaleSrcDim),
    .scaleDstDim (scaleDstDim)
`ifdef IPGU_SCHED_PERF_EN
    ,
    .stallCnt    (stallCnt),
    .scaleWaitCnt(scaleWaitCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] row;
    logic [8:0] col;
    logic [2:0] lvl;
    logic       last;
  } win_t;

  win_t        expQ[$];
  logic [17:0] expScale[$];

  int total = 0;
  int bad   = 0;

  // Bench-side state shared between the processes below.
  int phase      = 0;   // 1: directed pass, 2: random pass
  int rdyMode    = 0;   // 0: ready tied high except the directed hold, 1: random
  int ackMode    = 0;   // 0: directed delays, 1: random 1-20
  int holdCnt    = 0;
  int accepts    = 0;
  int scaleRises = 0;
  int doneCnt    = 0;
  int stallCyc   = 0;
  int req0Cyc    = 0;
  int reqVldClash = 0;
  int lastLvl    = -1;
  bit donePend   = 0;
  bit afterHold  = 0;
  bit prevReq    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Golden model: raster walk over the six level dims plus the scale requests.
  task automatic pushPass();
    int dims[6] = '{300, 240, 180, 120, 60, 20};
    win_t w;
    for (int l = 0; l < 6; l++) begin
      for (int r = 0; r <= dims[l] - 20; r += 10) begin
        for (int c = 0; c <= dims[l] - 20; c += 10) begin
          w.row  = 9'(r);
          w.col  = 9'(c);
          w.lvl  = 3'(l);
          w.last = (r == dims[l] - 20) && (c == dims[l] - 20);
          expQ.push_back(w);
        end
      end
      if (l < 5) expScale.push_back({9'(dims[l]), 9'(dims[l+1])});
    end
  endtask

  // Ready driver: updates just after each active edge.
  initial begin
    winRdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdyMode == 0) begin
        if (winVld && winLevel == 3'd0 && winRow == 9'd10 && winCol == 9'd20 && holdCnt < 5) begin
          winRdy = 1'b0;
          holdCnt++;
        end else begin
          winRdy = 1'b1;
        end
      end else begin
        winRdy = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Acknowledge driver: pulses scaleAck on the ackDelay-th cycle of scaleReq.
  initial begin
    int reqCyc;
    int ackDelay;
    reqCyc   = 0;
    ackDelay = 1;
    scaleAck = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (scaleReq && !scaleAck) begin
        reqCyc++;
        if (reqCyc == 1) begin
          if (ackMode == 1) ackDelay = $urandom_range(1, 20);
          else ackDelay = (scaleSrcDim == 9'd300) ? 100 : 3;
        end
        if (reqCyc >= ackDelay) scaleAck = 1'b1;
      end else begin
        scaleAck = 1'b0;
        reqCyc   = 0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    win_t        w;
    logic [17:0] s;
    if (rst) begin
      lastLvl   = -1;
      donePend  = 0;
      afterHold = 0;
      prevReq   = 0;
    end else begin
      if (done) doneCnt++;
      if (donePend) begin
        chk("busy cycle after done", 32'(busy), 32'd0);
        chk("done single cycle", 32'(done), 32'd0);
        donePend = 0;
      end
      if (lastLvl >= 0) begin
        if (lastLvl < 5) begin
          chk("scaleReq one cycle after level end", 32'(scaleReq), 32'd1);
        end else begin
          chk("done one cycle after last window", 32'(done), 32'd1);
          chk("busy during done", 32'(busy), 32'd1);
          donePend = 1;
        end
        lastLvl = -1;
      end
      if (afterHold) begin
        chk("vld after hold", 32'(winVld), 32'd1);
        chk("row after hold", 32'(winRow), 32'd10);
        chk("col after hold", 32'(winCol), 32'd30);
        afterHold = 0;
      end
      if (scaleReq && !prevReq) begin
        scaleRises++;
        if (expScale.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scale request: got src=%0d with none expected", scaleSrcDim);
        end else begin
          s = expScale.pop_front();
          chk("scaleSrcDim", 32'(scaleSrcDim), 32'(s[17:9]));
          chk("scaleDstDim", 32'(scaleDstDim), 32'(s[8:0]));
        end
      end
      if (scaleReq && winVld) reqVldClash++;
      if (phase == 1 && scaleReq && scaleSrcDim == 9'd300) req0Cyc++;
      if (phase == 1 && winVld && !winRdy) begin
        stallCyc++;
        chk("stall row", 32'(winRow), 32'd10);
        chk("stall col", 32'(winCol), 32'd20);
        chk("stall level", 32'(winLevel), 32'd0);
      end
      if (winVld && winRdy) begin
        accepts++;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL window: got (%0d,%0d) lvl %0d with none expected",
                   winRow, winCol, winLevel);
        end else begin
          w = expQ.pop_front();
          chk("winRow", 32'(winRow), 32'(w.row));
          chk("winCol", 32'(winCol), 32'(w.col));
          chk("winLevel", 32'(winLevel), 32'(w.lvl));
          chk("winLast", 32'(winLast), 32'(w.last));
        end
        if (winLast) lastLvl = int'(winLevel);
        if (phase == 1 && winLevel == 3'd0 && winRow == 9'd10 && winCol == 9'd20) afterHold = 1;
      end
      prevReq = scaleReq;
    end
  end

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b1;

    // Reset with start held high: everything stays quiet.
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset winVld", 32'(winVld), 32'd0);
    chk("reset scaleReq", 32'(scaleReq), 32'd0);
    chk("reset winRow", 32'(winRow), 32'd0);
    chk("reset winCol", 32'(winCol), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);

    // Pass 1: directed backpressure and slow acknowledge, aborted by reset.
    phase = 1;
    holdCnt = 0;
    pushPass();
    chk("idle winVld", 32'(winVld), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start to winVld", 32'(winVld), 32'd1);
    chk("busy with first winVld", 32'(busy), 32'd1);

    n = 0;
    while (!(winVld && winLevel == 3'd1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("level 1 reached in time", 32'(n < 3000), 32'd1);
    // Restart attempt mid-pass; the scoreboard would catch any disturbance.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    n = 0;
    while (!(scaleReq && scaleSrcDim == 9'd180) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("level 2 scale reached in time", 32'(n < 3000), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort winVld", 32'(winVld), 32'd0);
    chk("abort scaleReq", 32'(scaleReq), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort winLevel", 32'(winLevel), 32'd0);
    chk("stall cycles on (10,20)", 32'(stallCyc), 32'd5);
    chk("level 0 scaleReq cycles", 32'(req0Cyc), 32'd100);
    chk("no done in aborted pass", 32'(doneCnt), 32'd0);
    chk("scaleReq/winVld overlap pass 1", 32'(reqVldClash), 32'd0);
    repeat (3) @(negedge clk);
    chk("done stays low in reset", 32'(doneCnt), 32'd0);
    expQ.delete();
    expScale.delete();
    accepts     = 0;
    scaleRises  = 0;
    reqVldClash = 0;
    phase       = 2;
    rdyMode     = 1;
    ackMode     = 1;
    rst         = 1'b0;
    @(negedge clk);

    // Pass 2: full pass under random ready and random acknowledge delays.
    pushPass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (doneCnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("pass 2 done in time", 32'(n < 20000), 32'd1);
    repeat (3) @(negedge clk);
    chk("accepted windows", 32'(accepts), 32'd1806);
    chk("scaleReq rising edges", 32'(scaleRises), 32'd5);
    chk("windows left unseen", 32'(expQ.size()), 32'd0);
    chk("scale requests left unseen", 32'(expScale.size()), 32'd0);
    chk("scaleReq/winVld overlap pass 2", 32'(reqVldClash), 32'd0);
    chk("done pulses", 32'(doneCnt), 32'd1);
    chk("busy idle after pass", 32'(busy), 32'd0);
    chk("winVld idle after pass", 32'(winVld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
